// File: rtl/arm_pipe_pkg.sv
// ---------------------------------------------------------------------------
// arm_pipe_pkg
//
// Shared definitions for the fetch side of the pipeline.
//   XLEN        : architectural word / address width
//   PC_STEP     : byte distance between consecutive instructions
//   ifq_entry_t : one queued instruction, {pc, instr}
//   pc_next()   : sequential successor of a fetch address (wraps mod 2^32)
// ---------------------------------------------------------------------------
package arm_pipe_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ifq_entry_t;

    // Plain unsigned add, so 0xFFFF_FFFC rolls over to 0x0000_0000.
    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// ---------------------------------------------------------------------------
// ifq_fifo
//
// Synchronous FIFO of ifq_entry_t used as the instruction queue storage.
// Head entry is presented combinationally from the read pointer.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   clear      in   synchronous flush (same effect as reset on the pointers)
//   push       in   write push_data at the tail
//   push_data  in   entry to write
//   pop        in   drop the head entry
//   head       out  current head entry (valid when count != 0)
//   count      out  number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module ifq_fifo
    import arm_pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 4
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  ifq_entry_t               push_data,
    input  logic                     pop,
    output ifq_entry_t               head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    ifq_entry_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push_ok;
    logic            pop_ok;

    // Defensive guards: the owner never overfills or over-drains, but a
    // stray request must not corrupt the pointers. A push into a full FIFO
    // is still legal when the head leaves in the same cycle.
    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count != FULL) || pop_ok);

    assign head = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; clear and reset both empty the FIFO.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage carries no reset; stale contents are never visible because
    // count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok && !(reset || clear)) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue
//
// Instruction fetch queue between an in-order instruction memory and the
// decode stage. Issues sequential fetch requests while credits remain
// (queued entries + outstanding requests < DEPTH), tags returning words
// with their PC, and flushes on redirect. Responses belonging to requests
// issued before a redirect are counted in 'drop' and discarded on arrival.
//
// Build option:
//   IFETCH_QUEUE_BYPASS_EN  when defined, a non-dropped response arriving
//                           while the queue is empty is forwarded to out_*
//                           in the same cycle (and only queued if not taken).
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   req_valid    out  fetch request valid
//   req_addr     out  fetch byte address
//   req_ready    in   memory accepts the request
//   rsp_valid    in   in-order response valid (no backpressure)
//   rsp_data     in   instruction word
//   redirect     in   branch/exception taken, flushes the queue
//   redirect_pc  in   new fetch address
//   out_valid    out  head instruction valid toward decode
//   out_ready    in   decode accepts
//   out_instr    out  head instruction word
//   out_pc       out  address of head instruction
// ---------------------------------------------------------------------------
module ifetch_queue
    import arm_pipe_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)(
    input  logic            clk,
    input  logic            reset,
    output logic            req_valid,
    output logic [XLEN-1:0] req_addr,
    input  logic            req_ready,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_SUM = (CW+1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   count;
    logic [CW:0]     occupancy;

    logic            req_fire;
    logic            rsp_fire;
    logic            rsp_take;
    logic            bypass_hit;
    logic            fifo_push;
    logic            fifo_pop;
    ifq_entry_t      fifo_head;
    ifq_entry_t      push_entry;

    // Queue storage; a redirect flushes it in the same cycle.
    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (count)
    );

    // Request side: every outstanding request owns a future queue slot, so
    // limiting queued + in-flight to DEPTH makes overflow impossible even
    // when a push and a pop meet on a full queue.
    always_comb begin
        occupancy = {1'b0, count} + {1'b0, inflight};
        req_valid = !reset && !redirect && (occupancy < DEPTH_SUM);
        req_addr  = fetch_pc;
        req_fire  = req_valid && req_ready;
    end

    // Response side: a response with nothing outstanding is ignored. A
    // response is kept only when no redirect is happening and nothing is
    // pending to drop.
    always_comb begin
        rsp_fire      = rsp_valid && (inflight != '0);
        rsp_take      = rsp_fire && !redirect && (drop == '0);
        push_entry.pc    = resp_pc;
        push_entry.instr = rsp_data;
    end

    // Output side: head of queue, or with bypass built in, the arriving
    // response when the queue is empty. A bypassed word not accepted this
    // cycle is pushed, so it reappears unchanged as the head next cycle.
    always_comb begin
        bypass_hit = 1'b0;
        out_instr  = fifo_head.instr;
        out_pc     = fifo_head.pc;
`ifdef IFETCH_QUEUE_BYPASS_EN
        bypass_hit = rsp_take && (count == '0);
        if (count == '0) begin
            out_instr = rsp_data;
            out_pc    = resp_pc;
        end
`endif
        out_valid  = !reset && !redirect && ((count != '0) || bypass_hit);
        fifo_pop   = out_valid && out_ready && (count != '0);
        fifo_push  = rsp_take && !(bypass_hit && out_ready);
    end

    // PC and credit tracking. On redirect no new request can fire, so the
    // requests still owed to us are exactly the old in-flight ones minus
    // any answered this cycle; all of them become drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            resp_pc  <= redirect_pc;
            inflight <= inflight - CW'(rsp_fire);
            drop     <= inflight - CW'(rsp_fire);
        end else begin
            if (req_fire) begin
                fetch_pc <= pc_next(fetch_pc);
            end
            if (rsp_take) begin
                resp_pc <= pc_next(resp_pc);
            end
            if (rsp_fire && (drop != '0)) begin
                drop <= drop - CW'(1);
            end
            inflight <= inflight + CW'(req_fire) - CW'(rsp_fire);
        end
    end

`ifndef SYNTHESIS
    // A response with no outstanding request means the memory misbehaved.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(rsp_valid && (inflight == '0)));
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// ---------------------------------------------------------------------------
// tb_ifetch_queue
//
// Self-checking bench for ifetch_queue. A behavioural model (queue of
// {pc, instr} entries plus credit counters) predicts the outputs every
// cycle; a simple in-order memory answers requests with random delay.
// Directed sequences cover start-up, stall, redirect and reset corners; a
// second instance checks address wrap-around from a high RESET_PC.
// ---------------------------------------------------------------------------
module tb_ifetch_queue;
    import arm_pipe_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [31:0] MAIN_RESET_PC = 32'h0000_0000;
`ifdef IFETCH_QUEUE_BYPASS_EN
    localparam bit BYPASS    = 1'b1;
    localparam int FIRST_OUT = 1;
`else
    localparam bit BYPASS    = 1'b0;
    localparam int FIRST_OUT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    logic        w_reset = 1'b1;
    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_out_valid;
    logic [31:0] w_out_instr;
    logic [31:0] w_out_pc;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    logic [31:0] m_fetch_pc;
    logic [31:0] m_resp_pc;
    int          m_inflight;
    int          m_drop;
    ifq_entry_t  m_q[$];
    logic [31:0] mem_q[$];

    // Last sampled DUT outputs
    logic        obs_req_valid;
    logic [31:0] obs_req_addr;
    logic        obs_out_valid;
    logic [31:0] obs_out_pc;
    logic [31:0] obs_out_instr;

    always #5 clk = ~clk;

    ifetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (MAIN_RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc)
    );

    ifetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'hFFFF_FFF8)
    ) dut_wrap (
        .clk         (clk),
        .reset       (w_reset),
        .req_valid   (w_req_valid),
        .req_addr    (w_req_addr),
        .req_ready   (1'b1),
        .rsp_valid   (1'b0),
        .rsp_data    (32'h0),
        .redirect    (1'b0),
        .redirect_pc (32'h0),
        .out_valid   (w_out_valid),
        .out_ready   (1'b0),
        .out_instr   (w_out_instr),
        .out_pc      (w_out_pc)
    );

    // Instruction word the memory returns for a given address.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[15:0], ~addr[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, want %h", tag, actual, expected);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, compare against the
    // model, then advance the model across the rising edge.
    task automatic applyStimulus(input bit rst, input bit rdy, input bit rsp_en,
                                 input bit redir, input logic [31:0] rpc,
                                 input bit ordy);
        bit         e_rsp, e_req_valid, e_out_valid, accept, byp, pop, req_fire;
        ifq_entry_t e_head, ent;
        @(negedge clk);
        e_rsp       = !rst && rsp_en && (mem_q.size() > 0);
        reset       = rst;
        req_ready   = rdy;
        rsp_valid   = e_rsp;
        rsp_data    = e_rsp ? mem_word(mem_q[0]) : $urandom;
        redirect    = redir;
        redirect_pc = rpc;
        out_ready   = ordy;
        #1;
        obs_req_valid = req_valid;
        obs_req_addr  = req_addr;
        obs_out_valid = out_valid;
        obs_out_pc    = out_pc;
        obs_out_instr = out_instr;

        accept = e_rsp && !redir && (m_drop == 0);
        byp    = BYPASS && accept && (m_q.size() == 0);
        if (rst) begin
            e_req_valid = 1'b0;
            e_out_valid = 1'b0;
        end else begin
            e_req_valid = !redir && ((m_q.size() + m_inflight) < DEPTH);
            e_out_valid = !redir && ((m_q.size() > 0) || byp);
        end
        if (m_q.size() > 0) begin
            e_head = m_q[0];
        end else begin
            e_head.pc    = m_resp_pc;
            e_head.instr = rsp_data;
        end

        checkOutput("req_valid", 32'(obs_req_valid), 32'(e_req_valid));
        checkOutput("out_valid", 32'(obs_out_valid), 32'(e_out_valid));
        if (e_req_valid) checkOutput("req_addr", obs_req_addr, m_fetch_pc);
        if (e_out_valid) begin
            checkOutput("out_pc", obs_out_pc, e_head.pc);
            checkOutput("out_instr", obs_out_instr, e_head.instr);
        end

        @(posedge clk);
        if (rst) begin
            m_q.delete();
            mem_q.delete();
            m_fetch_pc = MAIN_RESET_PC;
            m_resp_pc  = MAIN_RESET_PC;
            m_inflight = 0;
            m_drop     = 0;
        end else begin
            pop      = e_out_valid && ordy;
            req_fire = e_req_valid && rdy;
            if (req_fire) begin
                mem_q.push_back(m_fetch_pc);
                m_fetch_pc = m_fetch_pc + 32'd4;
                m_inflight++;
            end
            if (e_rsp) begin
                void'(mem_q.pop_front());
                m_inflight--;
            end
            if (redir) begin
                m_q.delete();
                m_drop     = m_inflight;
                m_fetch_pc = rpc;
                m_resp_pc  = rpc;
            end else begin
                if (e_rsp && (m_drop > 0)) m_drop--;
                if (pop && (m_q.size() > 0)) void'(m_q.pop_front());
                if (accept) begin
                    ent.pc    = m_resp_pc;
                    ent.instr = rsp_data;
                    if (!(byp && pop)) m_q.push_back(ent);
                    m_resp_pc = m_resp_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic do_reset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    // Step with ready memory until the first output appears; check its PC.
    task automatic expect_first_out(input string tag, input logic [31:0] pc);
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
            if (obs_out_valid) begin
                found = 1'b1;
                checkOutput(tag, obs_out_pc, pc);
            end
        end
        if (!found) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          n_req;
        logic [31:0] wexp;
        bit          r_rst, r_redir;
        logic [31:0] r_pc;

        // Address wrap from a RESET_PC near the top of the address space.
        repeat (2) @(posedge clk);
        @(negedge clk);
        w_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            wexp = 32'hFFFF_FFF8 + 32'(i * 4);
            checkOutput("wrap_req_valid", 32'(w_req_valid), 32'd1);
            checkOutput("wrap_req_addr", w_req_addr, wexp);
            @(negedge clk);
        end
        w_reset = 1'b1;

        // Start-up with an always-ready one-cycle memory.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
            checkOutput("seq_req_addr", obs_req_addr, 32'(i * 4));
            if (i == FIRST_OUT - 1) checkOutput("seq_out_early", 32'(obs_out_valid), 32'd0);
            if (i == FIRST_OUT) begin
                checkOutput("seq_out_valid", 32'(obs_out_valid), 32'd1);
                checkOutput("seq_out_pc", obs_out_pc, 32'h0);
            end
        end

        // Decode stalled: credits cap issue at DEPTH requests.
        do_reset();
        n_req = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            if (obs_req_valid) n_req++;
        end
        checkOutput("stall_req_count", 32'(n_req), 32'd4);
        checkOutput("stall_req_valid", 32'(obs_req_valid), 32'd0);
        checkOutput("stall_head_pc", obs_out_pc, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("stall_pop_req_valid", 32'(obs_req_valid), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("stall_resume_req_valid", 32'(obs_req_valid), 32'd1);
        checkOutput("stall_resume_req_addr", obs_req_addr, 32'd16);

        // Redirect with two requests outstanding and no response that cycle.
        do_reset();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
        expect_first_out("redir_first_pc", 32'h100);

        // Redirect coinciding with a response, three outstanding.
        do_reset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1);
        checkOutput("redir_rsp_out_valid", 32'(obs_out_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("drop1_out_valid", 32'(obs_out_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("drop2_out_valid", 32'(obs_out_valid), 32'd0);
        checkOutput("drop_req_addr", obs_req_addr, 32'h200);
        expect_first_out("redir_rsp_first_pc", 32'h200);

        // Reset mid-operation with three queued and one outstanding.
        do_reset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("pre_reset_out_valid", 32'(obs_out_valid), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("in_reset_req_valid", 32'(obs_req_valid), 32'd0);
        checkOutput("in_reset_out_valid", 32'(obs_out_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("post_reset_out_valid", 32'(obs_out_valid), 32'd0);
        checkOutput("post_reset_req_addr", obs_req_addr, MAIN_RESET_PC);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r_rst   = ($urandom_range(0, 299) == 0);
            r_redir = ($urandom_range(0, 19) == 0);
            r_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            applyStimulus(r_rst, ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0),
                          r_redir, r_pc, ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
